// File: rtl/seq_detect_ctrl_if.sv
// Handshake bundle between the word-level producer/consumer, one serial
// Mealy detector and seq_detect_ctrl.
//   slave  : controller view (accepts words, drives detector, emits result)
//   master : environment view (producer, consumer and detector)
// Signals:
//   in_valid/in_ready/in_word          word input handshake
//   det_rst/det_din/det_y              serial detector connection
//   out_valid/out_ready                result handshake
//   out_count/out_hit/out_first/out_last  result fields
interface seq_detect_ctrl_if #(
    parameter int W = 11
);
    localparam int CW = $clog2(W + 1);
    localparam int IW = $clog2(W);

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_word;
    logic          det_rst;
    logic          det_din;
    logic          det_y;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_count;
    logic          out_hit;
    logic [IW-1:0] out_first;
    logic [IW-1:0] out_last;

    modport slave (
        input  in_valid, in_word, det_y, out_ready,
        output in_ready, det_rst, det_din, out_valid,
               out_count, out_hit, out_first, out_last
    );

    modport master (
        output in_valid, in_word, det_y, out_ready,
        input  in_ready, det_rst, det_din, out_valid,
               out_count, out_hit, out_first, out_last
    );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Sequencing controller for a serial Mealy sequence detector.
// Accepts a W-bit word, keeps the detector in reset between jobs, shifts the
// word out MSB-first on det_din, and gathers det_y pulses into a hit count
// plus the bit indices of the first and last hit.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset (aborts any job)
//   bus  - seq_detect_ctrl_if slave modport (word in, detector, result out)
module seq_detect_ctrl #(
    parameter int W = 11
) (
    input  logic             clk,
    input  logic             rst,
    seq_detect_ctrl_if.slave bus
);
    localparam int CW = $clog2(W + 1);
    localparam int IW = $clog2(W);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state;
    logic [W-1:0]  shreg;
    logic [IW-1:0] idx;
    logic [CW-1:0] count;
    logic          hit;
    logic [IW-1:0] first;
    logic [IW-1:0] last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            shreg <= '0;
            idx   <= '0;
            count <= '0;
            hit   <= 1'b0;
            first <= '0;
            last  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // in_ready is high throughout IDLE, so in_valid alone is the accept
                    if (bus.in_valid) begin
                        shreg <= bus.in_word;
                        idx   <= IW'(W - 1);
                        count <= '0;
                        hit   <= 1'b0;
                        first <= '0;
                        last  <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // det_y is Mealy on the bit currently on det_din, whose index is idx
                    if (bus.det_y) begin
                        count <= count + 1'b1;
                        if (!hit) first <= idx;
                        last  <= idx;
                        hit   <= 1'b1;
                    end
                    shreg <= {shreg[W-2:0], 1'b0};
                    idx   <= idx - 1'b1;
                    if (idx == '0) state <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake and detector controls decode straight from the state register,
    // so an asynchronous reset is visible on them immediately.
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.det_rst   = (state != SHIFT);
    assign bus.det_din   = (state == SHIFT) && shreg[W-1];

    assign bus.out_count = count;
    assign bus.out_hit   = hit;
    assign bus.out_first = first;
    assign bus.out_last  = last;
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: an overlapping-1101 Mealy detector model closes
// the loop on det_din/det_y; expected results are queued at word launch and
// popped when out_valid appears.
module tb_seq_detect_ctrl;
    localparam int W = 11;

    typedef struct {
        logic [W-1:0] word;
        int           cnt;
        int           first;
        int           last;
        int           hit;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic force_y = 1'b0;
    logic [1:0] mst = 2'd0;
    int total = 0;
    int bad = 0;
    vec_t sbq[$];
    vec_t vecs[7];
    localparam logic [W-1:0] REF_WORD = 11'b11011011101;

    seq_detect_ctrl_if #(.W(W)) bus ();
    seq_detect_ctrl #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Overlapping 1101 detector: states = matched prefix length 0..3
    always @(posedge clk) begin
        if (bus.det_rst) mst <= 2'd0;
        else case (mst)
            2'd0: mst <= bus.det_din ? 2'd1 : 2'd0;
            2'd1: mst <= bus.det_din ? 2'd2 : 2'd0;
            2'd2: mst <= bus.det_din ? 2'd2 : 2'd3;
            default: mst <= bus.det_din ? 2'd1 : 2'd0;
        endcase
    end
    assign bus.det_y = ((mst == 2'd3) && bus.det_din) || force_y;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the first SHIFT cycle.
    task automatic start_job(input vec_t v);
        chk("in_ready_idle", bus.in_ready, 1);
        chk("det_rst_before_accept", bus.det_rst, 1);
        bus.in_valid = 1'b1;
        bus.in_word  = v.word;
        sbq.push_back(v);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Entered at the negedge of SHIFT cycle 1; returns at the first DONE negedge.
    task automatic finish_job(input bit toggle);
        int lat = 1;
        int low = 0;
        vec_t e;
        while (!bus.out_valid && lat < 40) begin
            if (!bus.det_rst) low++;
            if (toggle) begin
                bus.in_valid = lat[0];
                bus.in_word  = '1;
            end
            @(negedge clk);
            lat++;
        end
        bus.in_valid = 1'b0;
        chk("out_valid_timeout", bus.out_valid, 1);
        chk("latency_edges", lat - 1, W);
        chk("det_rst_low_cycles", low, W);
        if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty actual=0 expected=1");
        end else begin
            e = sbq.pop_front();
            chk("out_count", bus.out_count, e.cnt);
            chk("out_first", bus.out_first, e.first);
            chk("out_last", bus.out_last, e.last);
            chk("out_hit", bus.out_hit, e.hit);
        end
    endtask

    task automatic take_result();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("in_ready_after_take", bus.in_ready, 1);
        chk("out_valid_after_take", bus.out_valid, 0);
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{REF_WORD,       3, 7, 0, 1};
        vecs[1] = '{11'b00000000000, 0, 0, 0, 0};
        vecs[2] = '{11'b11011011011, 3, 7, 1, 1};
        vecs[3] = '{11'b00000001101, 1, 0, 0, 1};
        vecs[4] = '{11'b11111111111, 0, 0, 0, 0};
        vecs[5] = '{11'b01101000000, 1, 6, 6, 1};
        vecs[6] = '{11'b11010000000, 1, 7, 7, 1};

        bus.in_valid  = 1'b0;
        bus.in_word   = '0;
        bus.out_ready = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_det_rst", bus.det_rst, 1);
        chk("rst_det_din", bus.det_din, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_count", bus.out_count, 0);
        chk("rst_out_hit", bus.out_hit, 0);
        chk("rst_out_first", bus.out_first, 0);
        chk("rst_out_last", bus.out_last, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", bus.in_ready, 1);

        // Table-driven jobs
        foreach (vecs[i]) begin
            start_job(vecs[i]);
            finish_job(1'b0);
            take_result();
        end

        // Backpressure in DONE with a forced det_y, then back-to-back accept
        start_job(vecs[0]);
        finish_job(1'b0);
        force_y = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_out_count", bus.out_count, 3);
            chk("bp_out_first", bus.out_first, 7);
            chk("bp_out_last", bus.out_last, 0);
        end
        force_y = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_word   = vecs[6].word;
        sbq.push_back(vecs[6]);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("b2b_in_ready", bus.in_ready, 1);
        chk("b2b_det_rst", bus.det_rst, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        finish_job(1'b0);
        take_result();

        // det_y forced in IDLE leaves the held result alone
        force_y = 1'b1;
        repeat (3) @(negedge clk);
        force_y = 1'b0;
        chk("idle_y_count", bus.out_count, 1);
        chk("idle_y_last", bus.out_last, 7);

        // in_valid toggling during SHIFT must not reload
        start_job(vecs[0]);
        finish_job(1'b1);
        take_result();

        // out_ready held high: exactly one DONE cycle
        bus.out_ready = 1'b1;
        start_job(vecs[5]);
        finish_job(1'b0);
        @(negedge clk);
        chk("single_done_out_valid", bus.out_valid, 0);
        chk("single_done_in_ready", bus.in_ready, 1);
        bus.out_ready = 1'b0;

        // Asynchronous reset during the 5th SHIFT cycle
        start_job(vecs[0]);
        void'(sbq.pop_back());
        repeat (4) @(negedge clk);
        chk("pre_abort_det_rst", bus.det_rst, 0);
        #2 rst = 1'b1;
        #1;
        chk("abort_det_rst", bus.det_rst, 1);
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_in_ready", bus.in_ready, 1);
        chk("abort_out_count", bus.out_count, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        v = vecs[0];
        start_job(v);
        finish_job(1'b0);
        take_result();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
